bin_to_thto_seq: RTL and testbench
==================================

Name: bin_to_thto_seq

Overview:
- Multi-cycle binary-to-BCD converter. It sequences one shift-and-add-3 (double-dabble) correction step per clock instead of unrolling IVW-1 combinational adder stages.
- Provides a start/done handshake so a display or UART front-end can request conversions without the wide combinational path.
- Sits between the binary result producers (counters, ALU outputs) and the 7-segment / digit-select logic.

Parameters:
- IVW, 8, binary input width in bits (>=2).
- DIGITS, 3, number of BCD output digits.
- FVW, 4*DIGITS, BCD output width (derived; not overridden independently).

Ports:
- i_Clk, input, 1, system clock; all state on rising edge.
- i_Rst, input, 1, asynchronous active-high reset.
- i_Start, input, 1, request; sampled only when the FSM is in IDLE.
- i_Bin, input, IVW, binary value; captured on the accepted i_Start edge.
- o_Busy, output, 1, high while a conversion is in progress.
- o_Done, output, 1, one-cycle pulse when o_Full_Val is updated.
- o_Full_Val, output, FVW, BCD result: nibble 0 = units, nibble 1 = tens, etc.
- o_Ovf, output, 1, set with o_Done when the value exceeds 10^DIGITS-1.

Behaviour:
- Reset (async, i_Rst=1):
  - State goes to IDLE.
  - o_Busy, o_Done, o_Ovf and o_Full_Val are 0.
  - The internal shift register and iteration counter are cleared.
- States: IDLE, CONV.
- IDLE:
  - o_Busy=0.
  - If i_Start=1 at an edge: load bin_sr<=i_Bin, bcd_sr<=0, ovf_acc<=0, cnt<=IVW, then go to CONV.
  - o_Done is deasserted on the next edge in every case.
- CONV (o_Busy=1), one step per edge:
  - 1) Every BCD nibble >=5 gets +3, without carry between nibbles.
  - 2) {ovf_acc|bcd_carry, bcd_sr, bin_sr} is shifted left by 1. The bit leaving the top of bcd_sr ORs into ovf_acc.
  - 3) cnt decrements.
- Final step (cnt==1 at the edge):
  - o_Full_Val <= corrected-and-shifted bcd value.
  - o_Ovf <= ovf_acc including this step's carry-out.
  - o_Done <= 1 for exactly one cycle.
  - State returns to IDLE.
- Latency: i_Start sampled at edge E; o_Done and the new o_Full_Val are visible after edge E+IVW.
  - o_Busy is high after edges E..E+IVW-1 and low after edge E+IVW.
- o_Full_Val holds its last result between conversions. It is never partially updated during CONV.
- i_Start while in CONV is ignored (not queued). i_Bin changing during CONV has no effect.
- i_Start=1 in the cycle o_Done=1 is accepted, since the state is IDLE. Back-to-back throughput is one conversion per IVW+1 cycles.
- i_Start held high continuously restarts a conversion immediately after each o_Done.
- Overflow:
  - When 2^IVW-1 <= 10^DIGITS-1, o_Ovf is always 0.
  - Otherwise o_Ovf=1 when the input is >=10^DIGITS. o_Full_Val then holds the low DIGITS digits (value mod 10^DIGITS).
- Reset mid-CONV aborts the conversion: no o_Done, and o_Full_Val goes to 0.
- Counter width: $clog2(IVW+1).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then idle (IVW=8, DIGITS=3): after i_Rst release with no i_Start for 20 cycles, o_Full_Val=12'h000, o_Busy=0, o_Done=0, o_Ovf=0.
- Single conversions, i_Bin=8'd255 then 8'd0 then 8'd9:
  - 255 gives o_Full_Val=12'h255.
  - 0 gives 12'h000.
  - 9 gives 12'h009.
  - Each o_Done occurs exactly 8 edges after its i_Start edge; o_Ovf=0.
- Ignored request: start 8'd100, pulse i_Start with i_Bin=8'd77 at cycle 3 of CONV. Result is 12'h100, only one o_Done, and no second conversion follows.
- Back-to-back: i_Start held high with i_Bin=8'd128 then 8'd64, applied in the o_Done cycle. Results are 12'h128 then 12'h064, and o_Done pulses are 9 cycles apart.
- Overflow (IVW=8, DIGITS=2): i_Bin=8'd99 gives 8'h99, o_Ovf=0. i_Bin=8'd100 gives o_Ovf=1, o_Full_Val=8'h00. i_Bin=8'd255 gives o_Ovf=1, 8'h55.
- Async reset mid-CONV: assert i_Rst between clock edges at step 4 of a 200 conversion. Outputs go to 0 immediately, no o_Done ever appears, and the next request for 8'd42 returns 12'h042.

Source files
------------

// File: rtl/bin_to_thto_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// with a start/busy/done handshake and an overflow flag for truncated results.
module bin_to_thto_seq #(
  parameter int IVW    = 8,
  parameter int DIGITS = 3,
  parameter int FVW    = 4 * DIGITS
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  input  logic           i_Start,
  input  logic [IVW-1:0] i_Bin,
  output logic           o_Busy,
  output logic           o_Done,
  output logic [FVW-1:0] o_Full_Val,
  output logic           o_Ovf
);

  localparam int CW = $clog2(IVW + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t         state, state_nx;
  logic [IVW-1:0] bin_sr, bin_sr_nx;
  logic [FVW-1:0] bcd_sr, bcd_sr_nx, bcd_adj;
  logic [FVW-1:0] full_val_nx;
  logic           ovf_acc, ovf_acc_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           done_nx, ovf_nx;

  // Add-3 correction per nibble; each nibble is independent, so no carries.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[4*d +: 4] = (bcd_sr[4*d +: 4] >= 4'd5) ? bcd_sr[4*d +: 4] + 4'd3
                                                      : bcd_sr[4*d +: 4];
    end
  end

  always_comb begin
    state_nx    = state;
    bin_sr_nx   = bin_sr;
    bcd_sr_nx   = bcd_sr;
    ovf_acc_nx  = ovf_acc;
    cnt_nx      = cnt;
    full_val_nx = o_Full_Val;
    ovf_nx      = o_Ovf;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          bin_sr_nx  = i_Bin;
          bcd_sr_nx  = '0;
          ovf_acc_nx = 1'b0;
          cnt_nx     = CW'(IVW);
          state_nx   = CONV;
        end
      end
      CONV: begin
        // The digit bit pushed out of the top nibble means the value wrapped past 10^DIGITS.
        bin_sr_nx  = {bin_sr[IVW-2:0], 1'b0};
        bcd_sr_nx  = {bcd_adj[FVW-2:0], bin_sr[IVW-1]};
        ovf_acc_nx = ovf_acc | bcd_adj[FVW-1];
        cnt_nx     = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          full_val_nx = bcd_sr_nx;
          ovf_nx      = ovf_acc_nx;
          done_nx     = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      ovf_acc    <= 1'b0;
      cnt        <= '0;
      o_Full_Val <= '0;
      o_Ovf      <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      state      <= state_nx;
      bin_sr     <= bin_sr_nx;
      bcd_sr     <= bcd_sr_nx;
      ovf_acc    <= ovf_acc_nx;
      cnt        <= cnt_nx;
      o_Full_Val <= full_val_nx;
      o_Ovf      <= ovf_nx;
      o_Done     <= done_nx;
    end
  end

  assign o_Busy = (state == CONV);

endmodule

// File: tb/tb_bin_to_thto_seq.sv
// Bench for bin_to_thto_seq: a 3-digit and a 2-digit instance checked against
// a decimal arithmetic model of the conversion.
module tb_bin_to_thto_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start3 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin3 = '0, bin2 = '0;
  logic        busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0] full3;
  logic [7:0]  full2;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_thto_seq #(.IVW(8), .DIGITS(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start3), .i_Bin(bin3),
    .o_Busy(busy3), .o_Done(done3), .o_Full_Val(full3), .o_Ovf(ovf3)
  );

  bin_to_thto_seq #(.IVW(8), .DIGITS(2)) dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start2), .i_Bin(bin2),
    .o_Busy(busy2), .o_Done(done2), .o_Full_Val(full2), .o_Ovf(ovf2)
  );

  always #5 clk = ~clk;

  // Decimal digits of v mod 10^digits, packed as nibbles.
  function automatic logic [11:0] model_bcd(input int v, input int digits);
    int m = 1;
    int r;
    logic [11:0] b = '0;
    for (int i = 0; i < digits; i++) m = m * 10;
    r = v % m;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic model_ovf(input int v, input int digits);
    int m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return (v >= m);
  endfunction

  // One conversion on the chosen instance; lat counts edges from the start edge to o_Done.
  // proto_err counts cycles where busy was wrong or the result moved mid-conversion.
  task automatic run_conv(input int sel, input logic [7:0] v, output int lat,
                          output logic [11:0] val, output logic ov, output int proto_err);
    logic [11:0] prev;
    proto_err = 0;
    @(negedge clk);
    prev = (sel == 3) ? full3 : {4'h0, full2};
    if (sel == 3) begin start3 = 1'b1; bin3 = v; end
    else          begin start2 = 1'b1; bin2 = v; end
    @(negedge clk);
    start3 = 1'b0; start2 = 1'b0;
    bin3 = 8'($urandom); bin2 = 8'($urandom);
    lat = 0;
    while (!((sel == 3) ? done3 : done2) && lat < 40) begin
      if (!((sel == 3) ? busy3 : busy2)) proto_err++;
      if (((sel == 3) ? full3 : {4'h0, full2}) !== prev) proto_err++;
      @(negedge clk);
      lat++;
    end
    if ((sel == 3) ? busy3 : busy2) proto_err++;
    val = (sel == 3) ? full3 : {4'h0, full2};
    ov  = (sel == 3) ? ovf3 : ovf2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (full3 !== 12'h000) begin n_fail++; $display("FAIL reset_full: got %h want 000", full3); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy3); end
    n_checks++; if (done3 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done3); end
    n_checks++; if (ovf3 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf3); end
    n_checks++; if (full2 !== 8'h00) begin n_fail++; $display("FAIL reset_full2: got %h want 00", full2); end
  endtask

  task automatic test_single();
    logic [7:0]  vin [3] = '{8'd255, 8'd0, 8'd9};
    logic [11:0] vexp[3] = '{12'h255, 12'h000, 12'h009};
    int lat, perr;
    logic [11:0] val;
    logic ov;
    for (int i = 0; i < 3; i++) begin
      run_conv(3, vin[i], lat, val, ov, perr);
      n_checks++; if (val !== vexp[i]) begin n_fail++; $display("FAIL single_val %0d: got %h want %h", vin[i], val, vexp[i]); end
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL single_latency %0d: got %0d want 8", vin[i], lat); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL single_ovf %0d: got %b want 0", vin[i], ov); end
      n_checks++; if (perr !== 0) begin n_fail++; $display("FAIL single_protocol %0d: got %0d errors want 0", vin[i], perr); end
    end
  endtask

  task automatic test_ignored();
    int dones = 0, first_lat = -1, busy_after = 0;
    logic [11:0] v_at = '0;
    @(negedge clk);
    start3 = 1'b1; bin3 = 8'd100;
    @(negedge clk);
    start3 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 2) begin start3 = 1'b1; bin3 = 8'd77; end
      else start3 = 1'b0;
      if (done3) begin
        dones++;
        if (first_lat < 0) begin first_lat = k; v_at = full3; end
      end else if (first_lat >= 0 && busy3) busy_after++;
      @(negedge clk);
    end
    start3 = 1'b0;
    n_checks++; if (v_at !== 12'h100) begin n_fail++; $display("FAIL ignored_val: got %h want 100", v_at); end
    n_checks++; if (first_lat !== 8) begin n_fail++; $display("FAIL ignored_latency: got %0d want 8", first_lat); end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", dones); end
    n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL ignored_no_restart: got %0d busy cycles want 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    int k = 0, t1 = -1, t2 = -1;
    logic [11:0] v1 = '0, v2 = '0;
    @(negedge clk);
    start3 = 1'b1; bin3 = 8'd128;
    while (t2 < 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (done3) begin
        if (t1 < 0) begin t1 = k; v1 = full3; bin3 = 8'd64; end
        else begin t2 = k; v2 = full3; start3 = 1'b0; end
      end
    end
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (v1 !== 12'h128) begin n_fail++; $display("FAIL b2b_first: got %h want 128", v1); end
    n_checks++; if (v2 !== 12'h064) begin n_fail++; $display("FAIL b2b_second: got %h want 064", v2); end
    n_checks++; if (t1 !== 9) begin n_fail++; $display("FAIL b2b_first_time: got %0d want 9", t1); end
    n_checks++; if ((t2 - t1) !== 9) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 9", t2 - t1); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b want 0", busy3); end
  endtask

  task automatic test_overflow();
    logic [7:0] vin [3] = '{8'd99, 8'd100, 8'd255};
    logic [7:0] vexp[3] = '{8'h99, 8'h00, 8'h55};
    logic       oexp[3] = '{1'b0, 1'b1, 1'b1};
    int lat, perr;
    logic [11:0] val;
    logic ov;
    for (int i = 0; i < 3; i++) begin
      run_conv(2, vin[i], lat, val, ov, perr);
      n_checks++; if (val[7:0] !== vexp[i]) begin n_fail++; $display("FAIL ovf_val %0d: got %h want %h", vin[i], val[7:0], vexp[i]); end
      n_checks++; if (ov !== oexp[i]) begin n_fail++; $display("FAIL ovf_flag %0d: got %b want %b", vin[i], ov, oexp[i]); end
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL ovf_latency %0d: got %0d want 8", vin[i], lat); end
    end
  endtask

  task automatic test_random();
    int lat, perr, sel, v, digits;
    logic [11:0] val, vexp;
    logic ov;
    for (int i = 0; i < 16; i++) begin
      sel    = (i % 2 == 0) ? 3 : 2;
      digits = (sel == 3) ? 3 : 2;
      v      = int'($urandom_range(0, 255));
      run_conv(sel, 8'(v), lat, val, ov, perr);
      vexp = model_bcd(v, digits);
      n_checks++; if (val !== vexp) begin n_fail++; $display("FAIL rand_val d%0d %0d: got %h want %h", digits, v, val, vexp); end
      n_checks++; if (ov !== model_ovf(v, digits)) begin n_fail++; $display("FAIL rand_ovf d%0d %0d: got %b want %b", digits, v, ov, model_ovf(v, digits)); end
      n_checks++; if (lat !== 8 || perr !== 0) begin n_fail++; $display("FAIL rand_timing d%0d %0d: got lat %0d errs %0d want 8/0", digits, v, lat, perr); end
    end
  endtask

  task automatic test_reset_mid_conv();
    int lat, perr, dones = 0;
    logic [11:0] val;
    logic ov;
    run_conv(3, 8'd123, lat, val, ov, perr);
    n_checks++; if (val !== 12'h123) begin n_fail++; $display("FAIL midrst_pre: got %h want 123", val); end
    @(negedge clk);
    start3 = 1'b1; bin3 = 8'd200;
    @(negedge clk);
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (full3 !== 12'h000) begin n_fail++; $display("FAIL midrst_full: got %h want 000", full3); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy3); end
    n_checks++; if (done3 !== 1'b0 || ovf3 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got done %b ovf %b want 0/0", done3, ovf3); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done3) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    run_conv(3, 8'd42, lat, val, ov, perr);
    n_checks++; if (val !== 12'h042) begin n_fail++; $display("FAIL midrst_next: got %h want 042", val); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
